// File: rtl/osc_pkg.sv
// Shared types and defaults for the oscillator clock bank and its per-channel NCOs.
package osc_pkg;
  localparam int ACC_W_DEFAULT = 24;
  localparam int N_CH_DEFAULT  = 4;

  typedef logic [ACC_W_DEFAULT-1:0]        tune_t;
  typedef logic [$clog2(N_CH_DEFAULT)-1:0] osc_ch_t;
endpackage

// File: rtl/osc_nco_chan.sv
// One phase accumulator with live and pending tuning words. Outputs are registered.
// Priority: disable > sync > advance > hold. Pending words are applied on disable, sync or wrap.
module osc_nco_chan
  import osc_pkg::*;
#(
  parameter int ACC_W      = ACC_W_DEFAULT,
  parameter int GLITCHLESS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             adv_i,
  input  logic             wr_en_i,
  input  logic [ACC_W-1:0] wr_tune_i,
  output logic [ACC_W-1:0] phase_o,
  output logic             tick_o,
  output logic             pend_o
);

  logic [ACC_W-1:0] phase_q, phase_d;
  logic [ACC_W-1:0] tune_q, tune_d;
  logic [ACC_W-1:0] pend_tune_q, pend_tune_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             apply;

  always_comb begin
    sum         = {1'b0, phase_q} + {1'b0, tune_q};
    carry       = sum[ACC_W];
    apply       = ~en_i | sync_i | (adv_i & carry);
    phase_d     = phase_q;
    tick_d      = 1'b0;
    tune_d      = tune_q;
    pend_tune_d = pend_tune_q;
    pend_d      = pend_q;

    if (!en_i || sync_i) begin
      phase_d = '0;
    end else if (adv_i) begin
      phase_d = sum[ACC_W-1:0];
      tick_d  = carry;
    end

    if (GLITCHLESS == 0) begin
      if (wr_en_i) tune_d = wr_tune_i;
    end else begin
      // The old pending word is applied first; a same-cycle write becomes the new pending word.
      if (apply && pend_q) tune_d = pend_tune_q;
      if (wr_en_i) begin
        pend_tune_d = wr_tune_i;
        pend_d      = 1'b1;
      end else if (apply) begin
        pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= '0;
      tune_q      <= '0;
      pend_tune_q <= '0;
      pend_q      <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      tune_q      <= tune_d;
      pend_tune_q <= pend_tune_d;
      pend_q      <= pend_d;
      tick_q      <= tick_d;
    end
  end

  assign phase_o = phase_q;
  assign tick_o  = tick_q;
  assign pend_o  = pend_q;

endmodule

// File: rtl/osc_clock_bank.sv
// N_CH independent NCOs sharing a prescaler; phase_out has 1-cycle read latency.
// In glitchless mode a write to a channel with a pending word stalls (wr_ready low) until it is applied.
module osc_clock_bank
  import osc_pkg::*;
#(
  parameter  int N_CH       = N_CH_DEFAULT,
  parameter  int ACC_W      = ACC_W_DEFAULT,
  parameter  int PRESCALE   = 1,
  parameter  int GLITCHLESS = 1,
  localparam int CH_W       = $clog2(N_CH)
) (
  input  logic             sys_clk,
  input  logic             reset_n,
  input  logic [N_CH-1:0]  osc_enable,
  input  logic [N_CH-1:0]  sync_in,
  input  logic             wr_valid,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [ACC_W-1:0] wr_tune,
  output logic             wr_ready,
  input  logic [CH_W-1:0]  rd_ch,
  output logic [ACC_W-1:0] phase_out,
  output logic [N_CH-1:0]  osc_clk,
  output logic [N_CH-1:0]  osc_tick
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0]  ps_cnt_q, ps_cnt_d;
  logic             adv;
  logic             wr_acc;
  logic [N_CH-1:0]  pend_flag;
  logic [ACC_W-1:0] phase [N_CH];
  logic [ACC_W-1:0] phase_out_q, phase_out_d;

  // With PRESCALE=1 the counter sits at 0 and adv is permanently high.
  always_comb begin
    adv      = (ps_cnt_q == PS_W'(PRESCALE - 1));
    ps_cnt_d = adv ? '0 : ps_cnt_q + PS_W'(1);
  end

  assign wr_ready    = (GLITCHLESS == 0) ? 1'b1 : ~pend_flag[wr_ch];
  assign wr_acc      = wr_valid & wr_ready;
  assign phase_out_d = phase[rd_ch];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    osc_nco_chan #(
      .ACC_W      (ACC_W),
      .GLITCHLESS (GLITCHLESS)
    ) u_chan (
      .clk       (sys_clk),
      .rst_n     (reset_n),
      .en_i      (osc_enable[i]),
      .sync_i    (sync_in[i]),
      .adv_i     (adv),
      .wr_en_i   (wr_acc && (wr_ch == CH_W'(i))),
      .wr_tune_i (wr_tune),
      .phase_o   (phase[i]),
      .tick_o    (osc_tick[i]),
      .pend_o    (pend_flag[i])
    );
    assign osc_clk[i] = phase[i][ACC_W-1];
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      ps_cnt_q    <= '0;
      phase_out_q <= '0;
    end else begin
      ps_cnt_q    <= ps_cnt_d;
      phase_out_q <= phase_out_d;
    end
  end

  assign phase_out = phase_out_q;

endmodule

// File: tb/tb_osc_clock_bank.sv
// Bench for osc_clock_bank: three instances (glitchless, immediate-update, prescale-3) checked via a cycle-tagged scoreboard.
module tb_osc_clock_bank;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 2;

  logic sys_clk = 1'b0;
  logic reset_n;
  always #5 sys_clk = ~sys_clk;

  logic [N-1:0]  en    [3];
  logic [N-1:0]  sync  [3];
  logic          wv    [3];
  logic [CW-1:0] wch   [3];
  logic [CW-1:0] rch   [3];
  logic [W-1:0]  wt    [3];
  logic          wr    [3];
  logic [W-1:0]  po    [3];
  logic [N-1:0]  oclk  [3];
  logic [N-1:0]  otick [3];

  osc_clock_bank #(.N_CH(N), .ACC_W(W), .PRESCALE(1), .GLITCHLESS(1)) dut_a (
    .sys_clk(sys_clk), .reset_n(reset_n), .osc_enable(en[0]), .sync_in(sync[0]),
    .wr_valid(wv[0]), .wr_ch(wch[0]), .wr_tune(wt[0]), .wr_ready(wr[0]),
    .rd_ch(rch[0]), .phase_out(po[0]), .osc_clk(oclk[0]), .osc_tick(otick[0]));

  osc_clock_bank #(.N_CH(N), .ACC_W(W), .PRESCALE(1), .GLITCHLESS(0)) dut_b (
    .sys_clk(sys_clk), .reset_n(reset_n), .osc_enable(en[1]), .sync_in(sync[1]),
    .wr_valid(wv[1]), .wr_ch(wch[1]), .wr_tune(wt[1]), .wr_ready(wr[1]),
    .rd_ch(rch[1]), .phase_out(po[1]), .osc_clk(oclk[1]), .osc_tick(otick[1]));

  osc_clock_bank #(.N_CH(N), .ACC_W(W), .PRESCALE(3), .GLITCHLESS(1)) dut_c (
    .sys_clk(sys_clk), .reset_n(reset_n), .osc_enable(en[2]), .sync_in(sync[2]),
    .wr_valid(wv[2]), .wr_ch(wch[2]), .wr_tune(wt[2]), .wr_ready(wr[2]),
    .rd_ch(rch[2]), .phase_out(po[2]), .osc_clk(oclk[2]), .osc_tick(otick[2]));

  typedef struct {
    int cyc;
    int d;
    int s;
    int v;
  } exp_t;

  exp_t  q[$];
  exp_t  e;
  int    act;
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    r;
  int    prev;
  string sn [4] = '{"osc_tick", "osc_clk", "phase_out", "wr_ready"};

  // Hand-computed expected phase / tick / wr_ready sequences.
  int ph_b  [9]  = '{0, 64, 128, 192, 0, 64, 128, 192, 0};
  int tk_b  [9]  = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
  int ph_a3 [14] = '{32, 64, 96, 128, 160, 192, 224, 0, 128, 0, 64, 128, 192, 0};
  int tk_a3 [14] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1};
  int rd_a3 [14] = '{1, 1, 1, 0, 0, 0, 0, 1, 0, 1, 1, 1, 1, 1};
  int ph_a4 [9]  = '{32, 64, 96, 128, 160, 0, 32, 64, 96};
  int ph_c  [20] = '{0, 0, 128, 128, 128, 0, 0, 0, 128, 128, 128, 0, 0, 0, 128, 128, 0, 0, 0, 0};
  int tk_c  [20] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};

  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic int dut_val(int d, int s);
    case (s)
      0:       return int'(otick[d]);
      1:       return int'(oclk[d]);
      2:       return int'(po[d]);
      default: return int'(wr[d]);
    endcase
  endfunction

  // Scoreboard monitor: compares every expectation due by this cycle.
  always @(negedge sys_clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e   = q.pop_front();
      act = dut_val(e.d, e.s);
      n_cmp++;
      if (act != e.v) begin
        n_bad++;
        $display("FAIL %s dut%0d @cyc %0d: actual %0d, expected %0d", sn[e.s], e.d, cyc, act, e.v);
      end
    end
  end

  task automatic nxt();
    @(posedge sys_clk);
    #1;
  endtask

  // Expectation for the state after the next rising edge.
  task automatic expn(int d, int s, int v);
    q.push_back('{cyc + 1, d, s, v});
  endtask

  // Expectation for the current cycle (no edge in between).
  task automatic expc(int d, int s, int v);
    q.push_back('{cyc, d, s, v});
  endtask

  initial begin
    reset_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      en[d] = '1; sync[d] = '0; wv[d] = 1'b0;
      wch[d] = '0; rch[d] = '0; wt[d] = '0;
    end
    nxt();

    // T1: reset held with enables high, then released with zero tunes.
    for (int d = 0; d < 3; d++) begin
      expn(d, 0, 0); expn(d, 1, 0); expn(d, 2, 0); expn(d, 3, 1);
    end
    nxt();
    reset_n = 1'b1;
    r = cyc;
    for (int j = 0; j < 4; j++) begin
      for (int d = 0; d < 3; d++) begin
        expn(d, 0, 0); expn(d, 2, 0);
      end
      nxt();
    end

    // T2: immediate-update instance, ch0 tune 64.
    prev = 0;
    for (int j = 0; j < 9; j++) begin
      wv[1] = (j == 0); wch[1] = 2'd0; wt[1] = 8'd64; rch[1] = 2'd0;
      expn(1, 0, tk_b[j]);
      expn(1, 1, ph_b[j] >> 7);
      expn(1, 2, prev);
      expn(1, 3, 1);
      prev = ph_b[j];
      nxt();
    end
    wv[1] = 1'b0;

    // T3: glitchless ch1: load 32 while disabled, then retune to 128 mid-period.
    en[0] = 4'b1101; wv[0] = 1'b1; wch[0] = 2'd1; wt[0] = 8'd32; rch[0] = 2'd1;
    expn(0, 3, 0); expn(0, 2, 0);
    nxt();
    wv[0] = 1'b0;
    expn(0, 3, 1);
    nxt();
    en[0] = '1;
    prev = 0;
    for (int j = 0; j < 14; j++) begin
      wv[0] = (j >= 3 && j <= 8);
      wt[0] = (j == 3) ? 8'd128 : 8'd64;
      expn(0, 0, tk_a3[j] << 1);
      expn(0, 1, (ph_a3[j] >> 7) << 1);
      expn(0, 2, prev);
      expn(0, 3, rd_a3[j]);
      prev = ph_a3[j];
      nxt();
    end
    wv[0] = 1'b0;

    // T4: ch2 tune 32, hard-sync at phase 160.
    en[0] = 4'b1001; wv[0] = 1'b1; wch[0] = 2'd2; wt[0] = 8'd32; rch[0] = 2'd2;
    expn(0, 0, 0);
    nxt();
    wv[0] = 1'b0;
    expn(0, 0, 0);
    nxt();
    en[0] = 4'b1101;
    prev = 0;
    for (int j = 0; j < 9; j++) begin
      sync[0] = (j == 5) ? 4'b0100 : 4'b0000;
      expn(0, 0, 0);
      expn(0, 1, (ph_a4[j] >> 7) << 2);
      expn(0, 2, prev);
      prev = ph_a4[j];
      nxt();
    end
    sync[0] = '0;

    // T5: prescale-3 instance, ch0 tune 128, disabled after two ticks.
    for (int g = 0; g < 3 && ((cyc - r) % 3) != 1; g++) nxt();
    en[2] = 4'b1110; wv[2] = 1'b1; wch[2] = 2'd0; wt[2] = 8'd128; rch[2] = 2'd0;
    nxt();
    wv[2] = 1'b0;
    nxt();
    en[2] = '1;
    prev = 0;
    for (int j = 0; j < 20; j++) begin
      en[2] = (j >= 16) ? 4'b1110 : 4'b1111;
      expn(2, 0, tk_c[j]);
      expn(2, 1, ph_c[j] >> 7);
      expn(2, 2, prev);
      prev = ph_c[j];
      nxt();
    end

    // T6: async reset mid-cycle while ch3 holds a pending word.
    en[0] = '1; wv[0] = 1'b1; wch[0] = 2'd3; wt[0] = 8'd100; rch[0] = 2'd3;
    nxt();
    wv[0] = 1'b0;
    expc(0, 3, 0);
    nxt();
    #2;
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      expc(d, 0, 0); expc(d, 1, 0); expc(d, 2, 0);
    end
    expc(0, 3, 1);
    nxt();
    reset_n = 1'b1;
    en[0] = 4'b0111;
    expn(0, 2, 0); expn(0, 3, 1);
    nxt();
    en[0] = '1;
    for (int j = 0; j < 6; j++) begin
      expn(0, 0, 0); expn(0, 2, 0); expn(0, 3, 1);
      nxt();
    end

    nxt();
    nxt();
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: actual %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
